// File: rtl/multicycle_alu_pkg.sv
// Shared ALU control codes, FSM state encodings and defaults for the multicycle ALU.
package multicycle_alu_pkg;

   localparam int ALU_DATA_W = 32;

   localparam logic [3:0] ALU_CTL_AND = 4'h0;
   localparam logic [3:0] ALU_CTL_ADD = 4'h2;
   localparam logic [3:0] ALU_CTL_XOR = 4'h3;
   localparam logic [3:0] ALU_CTL_SLL = 4'h4;
   localparam logic [3:0] ALU_CTL_SRA = 4'h5;
   localparam logic [3:0] ALU_CTL_SUB = 4'h6;
   localparam logic [3:0] ALU_CTL_MUL = 4'h8;

   typedef enum logic [1:0] {
      ALU_ST_IDLE = 2'd0,
      ALU_ST_MUL  = 2'd1,
      ALU_ST_DONE = 2'd2
   } alu_state_e;

   function automatic logic isMulCtl(input logic [3:0] ctl);
      return ctl == ALU_CTL_MUL;
   endfunction

endpackage

// File: rtl/multicycle_alu_mul_iter.sv
// Iterative shift-add multiplier producing the low DATA_W bits of A*B.
// MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module mul_iter
   import multicycle_alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic              step_i,
   input  logic [DATA_W-1:0] op_a_i,
   input  logic [DATA_W-1:0] op_b_i,
   output logic              done_o,
   output logic [DATA_W-1:0] product_o
);

   localparam int CNT_W = $clog2(DATA_W);

   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] mcand_q, mcand_d;
   logic [DATA_W-1:0] mplier_q, mplier_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] accSum;
   logic [DATA_W-1:0] mplierShift;
   logic              lastIter;

   always_comb begin
      accSum      = acc_q + (mplier_q[0] ? mcand_q : '0);
      mplierShift = mplier_q >> 1;
      lastIter    = (cnt_q == CNT_W'(DATA_W - 1));
`ifdef MUL_EARLY_TERM_EN
      // Remaining partial products are all zero, so the sum is already final.
      lastIter    = lastIter | (mplierShift == '0);
`endif
   end

   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      if (start_i) begin
         acc_d    = '0;
         mcand_d  = op_a_i;
         mplier_d = op_b_i;
         cnt_d    = '0;
      end else if (step_i) begin
         acc_d    = accSum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplierShift;
         cnt_d    = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   assign done_o    = step_i & lastIter;
   assign product_o = accSum;

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: single-cycle logic/shift/add ops plus an iterative MUL behind valid/ready handshakes.
// MUL_EARLY_TERM_EN (handled in mul_iter) shortens MUL latency for small multipliers; results are unchanged.
module multicycle_alu
   import multicycle_alu_pkg::*;
#(
   parameter int DATA_W  = ALU_DATA_W,
   parameter int SHAMT_W = 5
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [3:0]        alu_ctl_i,
   input  logic [DATA_W-1:0] op_a_i,
   input  logic [DATA_W-1:0] op_b_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              busy_o
);

   alu_state_e        state_q;
   logic              rspValid_q;
   logic [DATA_W-1:0] rspData_q;
   logic              busy_q;

   logic              accept;
   logic              reqIsMul;
   logic [SHAMT_W-1:0] shamt;
   logic [DATA_W-1:0] aluResult_d;
   logic              mulDone;
   logic [DATA_W-1:0] mulProduct;

   assign req_ready_o = (state_q == ALU_ST_IDLE) | ((state_q == ALU_ST_DONE) & rsp_ready_i);
   assign accept      = req_valid_i & req_ready_o;
   assign reqIsMul    = isMulCtl(alu_ctl_i);
   assign shamt       = op_b_i[SHAMT_W-1:0];

   always_comb begin
      aluResult_d = '0;
      case (alu_ctl_i)
         ALU_CTL_AND: aluResult_d = op_a_i & op_b_i;
         ALU_CTL_XOR: aluResult_d = op_a_i ^ op_b_i;
         ALU_CTL_SLL: aluResult_d = op_a_i << shamt;
         ALU_CTL_ADD: aluResult_d = op_a_i + op_b_i;
         ALU_CTL_SUB: aluResult_d = op_a_i - op_b_i;
         ALU_CTL_SRA: aluResult_d = $signed(op_a_i) >>> shamt;
         default:     aluResult_d = '0;
      endcase
   end

   mul_iter #(
      .DATA_W(DATA_W)
   ) u_mul_iter (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .start_i   (accept & reqIsMul),
      .step_i    (state_q == ALU_ST_MUL),
      .op_a_i    (op_a_i),
      .op_b_i    (op_b_i),
      .done_o    (mulDone),
      .product_o (mulProduct)
   );

   // IDLE and DONE share the accept path so a new op can start the same cycle a result is consumed.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ALU_ST_IDLE;
         rspValid_q <= 1'b0;
         rspData_q  <= '0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            ALU_ST_MUL: begin
               if (mulDone) begin
                  state_q    <= ALU_ST_DONE;
                  rspValid_q <= 1'b1;
                  rspData_q  <= mulProduct;
                  busy_q     <= 1'b0;
               end
            end
            default: begin
               if (accept) begin
                  if (reqIsMul) begin
                     state_q    <= ALU_ST_MUL;
                     rspValid_q <= 1'b0;
                     busy_q     <= 1'b1;
                  end else begin
                     state_q    <= ALU_ST_DONE;
                     rspValid_q <= 1'b1;
                     rspData_q  <= aluResult_d;
                  end
               end else if ((state_q == ALU_ST_DONE) && rsp_ready_i) begin
                  state_q    <= ALU_ST_IDLE;
                  rspValid_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign rsp_valid_o = rspValid_q;
   assign rsp_data_o  = rspData_q;
   assign busy_o      = busy_q;

endmodule
